axi_iob_resp_bridge: RTL and testbench

AXI4 slave (responder) that terminates bursts from `axi_interconnect` master ports and replays them as single-beat native (valid/ready) accesses to a downstream memory or peripheral. It is the responder counterpart of the system's AXI initiator. It lets the simulation and FPGA tops back the DDR address space with any native-interface memory instead of `axi_ram`. One burst is in flight at a time; reads and writes share one state machine.

---
 rtl/axi_iob_resp_bridge_pkg.sv | 27 ++
 rtl/axi_iob_resp_bridge_if.sv | 63 ++++++
 rtl/axi_burst_addr_gen.sv | 25 ++
 rtl/axi_iob_resp_bridge.sv | 162 ++++++++++++++++
 tb/tb_axi_iob_resp_bridge.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_iob_resp_bridge_pkg.sv
// Shared encodings for the AXI-to-native responder bridge.
package axi_iob_resp_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WDATA = 3'd1;
    localparam logic [2:0] ST_WMEM  = 3'd2;
    localparam logic [2:0] ST_BRESP = 3'd3;
    localparam logic [2:0] ST_RMEM  = 3'd4;
    localparam logic [2:0] ST_RDATA = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        WDATA = ST_WDATA,
        WMEM  = ST_WMEM,
        BRESP = ST_BRESP,
        RMEM  = ST_RMEM,
        RDATA = ST_RDATA
    } state_t;

endpackage

// File: rtl/axi_iob_resp_bridge_if.sv
// AXI4 bus bundle between an initiator and the responder bridge.
interface axi_iob_resp_bridge_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for an AXI burst; WRAP is treated as INCR.
module axi_burst_addr_gen
    import axi_iob_resp_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;

    always_comb begin
        step = ADDR_W'(1) << size;
        unique case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR,
            BURST_WRAP:  next_addr = addr + step;
            default:     next_addr = addr + step;
        endcase
    end

endmodule

// File: rtl/axi_iob_resp_bridge.sv
// AXI4 responder that replays each burst beat as a native valid/ready access.
module axi_iob_resp_bridge
    import axi_iob_resp_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
) (
    input  logic                clk,
    input  logic                rst,
    axi_iob_resp_bridge_if.slave s_axi,
    output logic                valid,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                ready
);

    localparam logic [2:0] SIZE_MAX = (DATA_W == 64) ? 3'd3 : 3'd2;

    state_t              state_q, state_d;
    logic                last_wr_q;
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [7:0]          len_q, cnt_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic                err_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_go, ar_go, w_hs, adv, last_beat;

    assign last_beat = (cnt_q == len_q);

    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (addr_nxt)
    );

    always_comb begin
        state_d = state_q;
        aw_go   = 1'b0;
        ar_go   = 1'b0;
        w_hs    = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // on contention the side not granted last time wins
                if (!rst && s_axi.awvalid &&
                    (!s_axi.arvalid || !last_wr_q)) begin
                    aw_go   = 1'b1;
                    state_d = WDATA;
                end else if (!rst && s_axi.arvalid) begin
                    ar_go   = 1'b1;
                    state_d = RMEM;
                end
            end
            WDATA: begin
                if (s_axi.wvalid) begin
                    w_hs = 1'b1;
                    if (err_q || s_axi.wstrb == '0) begin
                        adv     = !last_beat;
                        state_d = last_beat ? BRESP : WDATA;
                    end else begin
                        state_d = WMEM;
                    end
                end
            end
            WMEM: begin
                if (ready) begin
                    adv     = !last_beat;
                    state_d = last_beat ? BRESP : WDATA;
                end
            end
            BRESP: begin
                if (s_axi.bready) state_d = IDLE;
            end
            RMEM: begin
                if (err_q || ready) state_d = RDATA;
            end
            RDATA: begin
                if (s_axi.rready) begin
                    adv     = !last_beat;
                    state_d = last_beat ? IDLE : RMEM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (aw_go || ar_go) begin
                last_wr_q <= aw_go;
                cnt_q     <= '0;
            end
            if (aw_go) begin
                id_q    <= s_axi.awid;
                addr_q  <= s_axi.awaddr;
                len_q   <= s_axi.awlen;
                size_q  <= s_axi.awsize;
                burst_q <= s_axi.awburst;
                err_q   <= s_axi.awsize > SIZE_MAX;
            end else if (ar_go) begin
                id_q    <= s_axi.arid;
                addr_q  <= s_axi.araddr;
                len_q   <= s_axi.arlen;
                size_q  <= s_axi.arsize;
                burst_q <= s_axi.arburst;
                err_q   <= s_axi.arsize > SIZE_MAX;
            end
            if (w_hs) begin
                wdata_q <= s_axi.wdata;
                wstrb_q <= s_axi.wstrb;
                if (s_axi.wlast != last_beat) err_q <= 1'b1;
            end
            // an errored read beat returns zero data without touching memory
            if (state_q == RMEM && state_d == RDATA) begin
                rdata_q <= err_q ? '0 : rdata;
            end
            if (adv) begin
                cnt_q  <= cnt_q + 8'd1;
                addr_q <= addr_nxt;
            end
        end
    end

    assign s_axi.awready = aw_go;
    assign s_axi.arready = ar_go;
    assign s_axi.wready  = (state_q == WDATA);
    assign s_axi.bvalid  = (state_q == BRESP);
    assign s_axi.bid     = id_q;
    assign s_axi.bresp   = (state_q == BRESP && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.rvalid  = (state_q == RDATA);
    assign s_axi.rid     = id_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = (state_q == RDATA && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.rlast   = (state_q == RDATA) && last_beat;

    assign valid = (state_q == WMEM) || (state_q == RMEM && !err_q);
    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign wstrb = (state_q == WMEM) ? wstrb_q : '0;

endmodule

// File: tb/tb_axi_iob_resp_bridge.sv
// Directed bench: AXI initiator tasks plus a native memory responder.
module tb_axi_iob_resp_bridge;
    import axi_iob_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    axi_iob_resp_bridge_if #(.ADDR_W(24), .DATA_W(32), .ID_W(1)) ax ();

    axi_iob_resp_bridge #(.ADDR_W(24), .DATA_W(32), .ID_W(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (ax),
        .valid (valid),
        .addr  (addr),
        .wdata (wdata),
        .wstrb (wstrb),
        .rdata (rdata),
        .ready (ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int mem_wait = 0;
    int busy = 0;
    int acc_n = 0;
    int vcyc = 0;
    int ovl = 0;
    logic [23:0] acc_addr [16];
    logic [31:0] acc_wdata [16];
    logic [3:0]  acc_wstrb [16];
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [1:0]  rd_resp [16];
    logic        rd_id [16];
    logic [1:0]  resp;
    logic        bid;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic sig(input int k);
        case (k)
            0: return ax.awready;
            1: return ax.arready;
            2: return ax.wready;
            3: return ax.bvalid;
            4: return ax.rvalid;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [127:0] out_vec();
        return {valid, addr, wdata, wstrb, ax.awready, ax.arready,
                ax.wready, ax.bvalid, ax.bid, ax.bresp, ax.rvalid,
                ax.rid, ax.rdata, ax.rresp, ax.rlast};
    endfunction

    task automatic wait_sig(input int k, input string tag);
        int t = 0;
        #1;
        while (!sig(k) && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk({"wait_", tag}, sig(k), 1'b1);
    endtask

    // native memory: completes after mem_wait idle cycles, one-cycle ready
    initial begin
        ready = 1'b0;
        rdata = '0;
        forever begin
            @(negedge clk);
            if (ready) ready = 1'b0;
            else if (!valid) busy = 0;
            else if (busy < mem_wait) busy++;
            else begin
                ready = 1'b1;
                busy  = 0;
                rdata = {8'hC3, addr};
                if (acc_n < 16) begin
                    acc_addr[acc_n]  = addr;
                    acc_wdata[acc_n] = wdata;
                    acc_wstrb[acc_n] = wstrb;
                end
                acc_n++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (valid === 1'b1) vcyc++;
            if (ax.awready === 1'b1 && ax.arready === 1'b1) ovl++;
        end
    end

    task automatic aw_phase(input logic id, input logic [23:0] a,
                            input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bu);
        @(negedge clk);
        ax.awid = id; ax.awaddr = a; ax.awlen = len;
        ax.awsize = sz; ax.awburst = bu; ax.awvalid = 1'b1;
        wait_sig(0, "awready");
        @(negedge clk);
        ax.awvalid = 1'b0;
    endtask

    task automatic w_beats(input int first, input int lastb, input int len,
                           input logic [31:0] d0, input logic [3:0] st,
                           input int early);
        for (int b = first; b <= lastb; b++) begin
            ax.wdata  = d0 + 32'(b);
            ax.wstrb  = st;
            ax.wlast  = (b == len) || (b == early);
            ax.wvalid = 1'b1;
            wait_sig(2, "wready");
            @(negedge clk);
            ax.wvalid = 1'b0;
        end
    endtask

    task automatic b_phase(output logic [1:0] r, output logic id);
        ax.bready = 1'b1;
        wait_sig(3, "bvalid");
        r  = ax.bresp;
        id = ax.bid;
        @(negedge clk);
        ax.bready = 1'b0;
    endtask

    task automatic r_beats(input int len, input int hold);
        for (int b = 0; b <= len; b++) begin
            wait_sig(4, "rvalid");
            rd_data[b] = ax.rdata;
            rd_last[b] = ax.rlast;
            rd_resp[b] = ax.rresp;
            rd_id[b]   = ax.rid;
            if (b == 0) begin
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    #1;
                    chk("r_hold", {ax.rvalid, ax.rlast, ax.rdata},
                        {1'b1, rd_last[0], rd_data[0]});
                end
            end
            ax.rready = 1'b1;
            @(negedge clk);
            ax.rready = 1'b0;
        end
    endtask

    task automatic do_read(input logic id, input logic [23:0] a,
                           input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input int hold);
        @(negedge clk);
        ax.arid = id; ax.araddr = a; ax.arlen = len;
        ax.arsize = sz; ax.arburst = bu; ax.arvalid = 1'b1;
        wait_sig(1, "arready");
        @(negedge clk);
        ax.arvalid = 1'b0;
        r_beats(int'(len), hold);
    endtask

    int v0;
    logic bseen;

    initial begin
        ax.awid = '0; ax.awaddr = '0; ax.awlen = '0; ax.awsize = '0;
        ax.awburst = '0; ax.awvalid = 1'b0;
        ax.wdata = '0; ax.wstrb = '0; ax.wlast = 1'b0; ax.wvalid = 1'b0;
        ax.bready = 1'b0;
        ax.arid = '0; ax.araddr = '0; ax.arlen = '0; ax.arsize = '0;
        ax.arburst = '0; ax.arvalid = 1'b0; ax.rready = 1'b0;

        // reset with both address valids raised
        rst = 1'b1;
        ax.awvalid = 1'b1;
        ax.arvalid = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("reset_outputs", out_vec(), '0);
        ax.awvalid = 1'b0;
        ax.arvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // single write
        acc_n = 0;
        aw_phase(1'b1, 24'h100, 8'd0, 3'd2, BURST_INCR);
        w_beats(0, 0, 0, 32'hDEADBEEF, 4'hF, -1);
        b_phase(resp, bid);
        chk("wr1_resp", resp, RESP_OKAY);
        chk("wr1_bid", bid, 1'b1);
        chk("wr1_count", acc_n, 1);
        chk("wr1_acc", {acc_addr[0], acc_wdata[0], acc_wstrb[0]},
            {24'h100, 32'hDEADBEEF, 4'hF});

        // INCR read with slow memory
        acc_n = 0;
        mem_wait = 3;
        do_read(1'b0, 24'h200, 8'd3, 3'd2, BURST_INCR, 0);
        chk("rd_count", acc_n, 4);
        for (int b = 0; b < 4; b++) begin
            chk("rd_addr", {acc_addr[b], acc_wstrb[b]},
                {24'h200 + 24'(4 * b), 4'h0});
            chk("rd_beat", {rd_data[b], rd_last[b], rd_resp[b], rd_id[b]},
                {8'hC3, 24'h200 + 24'(4 * b), b == 3, RESP_OKAY, 1'b0});
        end
        mem_wait = 0;

        // FIXED write, then a read held off for 5 cycles
        acc_n = 0;
        aw_phase(1'b0, 24'h300, 8'd2, 3'd2, BURST_FIXED);
        w_beats(0, 2, 2, 32'h1000, 4'h3, -1);
        b_phase(resp, bid);
        chk("fix_resp", resp, RESP_OKAY);
        chk("fix_count", acc_n, 3);
        for (int b = 0; b < 3; b++)
            chk("fix_acc", {acc_addr[b], acc_wdata[b], acc_wstrb[b]},
                {24'h300, 32'h1000 + 32'(b), 4'h3});
        do_read(1'b1, 24'h400, 8'd1, 3'd2, BURST_INCR, 5);
        chk("hold_beat0", {rd_data[0], rd_last[0], rd_id[0]},
            {8'hC3, 24'h400, 1'b0, 1'b1});
        chk("hold_beat1", {rd_data[1], rd_last[1]}, {8'hC3, 24'h404, 1'b1});

        // simultaneous requests: write first, then read
        acc_n = 0;
        @(negedge clk);
        ax.awid = 1'b0; ax.awaddr = 24'h500; ax.awlen = 8'd0;
        ax.awsize = 3'd2; ax.awburst = BURST_INCR; ax.awvalid = 1'b1;
        ax.arid = 1'b1; ax.araddr = 24'h600; ax.arlen = 8'd0;
        ax.arsize = 3'd2; ax.arburst = BURST_INCR; ax.arvalid = 1'b1;
        #1 chk("arb1_grant", {ax.awready, ax.arready}, 2'b10);
        @(negedge clk);
        ax.awvalid = 1'b0;
        #1 chk("arb1_ar_blocked", ax.arready, 1'b0);
        w_beats(0, 0, 0, 32'h11112222, 4'hF, -1);
        ax.awaddr  = 24'h700;
        ax.awvalid = 1'b1;
        b_phase(resp, bid);
        chk("arb1_resp", resp, RESP_OKAY);
        #1 chk("arb2_grant", {ax.awready, ax.arready}, 2'b01);
        @(negedge clk);
        ax.arvalid = 1'b0;
        r_beats(0, 0);
        chk("arb2_rd", {rd_data[0], rd_id[0], rd_last[0]},
            {8'hC3, 24'h600, 1'b1, 1'b1});
        wait_sig(0, "awready_3");
        @(negedge clk);
        ax.awvalid = 1'b0;
        w_beats(0, 0, 0, 32'h33334444, 4'hF, -1);
        b_phase(resp, bid);
        chk("arb_order", {acc_addr[0], acc_addr[1], acc_addr[2]},
            {24'h500, 24'h600, 24'h700});
        chk("aw_ar_overlap", ovl, 0);

        // oversize read: zero data, SLVERR, no native access
        v0 = vcyc;
        do_read(1'b0, 24'h800, 8'd1, 3'd3, BURST_INCR, 0);
        chk("sz_valid", vcyc - v0, 0);
        chk("sz_beats", {rd_data[0], rd_resp[0], rd_last[0],
                         rd_data[1], rd_resp[1], rd_last[1]},
            {32'h0, RESP_SLVERR, 1'b0, 32'h0, RESP_SLVERR, 1'b1});

        // early wlast on beat 0
        aw_phase(1'b0, 24'h880, 8'd1, 3'd2, BURST_INCR);
        w_beats(0, 1, 1, 32'h77, 4'hF, 0);
        b_phase(resp, bid);
        chk("wlast_resp", resp, RESP_SLVERR);

        // reset while waiting on memory for the second beat
        mem_wait = 20;
        aw_phase(1'b1, 24'h900, 8'd3, 3'd2, BURST_INCR);
        w_beats(0, 1, 3, 32'hA0, 4'hF, -1);
        #1 chk("rst_pre_valid", {valid, addr}, {1'b1, 24'h904});
        rst = 1'b1;
        @(negedge clk);
        #1 chk("rst_mid_outputs", out_vec(), '0);
        rst = 1'b0;
        ax.bready = 1'b1;
        bseen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1 bseen = bseen | ax.bvalid | valid;
        end
        ax.bready = 1'b0;
        chk("rst_no_resp", bseen, 1'b0);

        mem_wait = 0;
        acc_n = 0;
        aw_phase(1'b0, 24'hA00, 8'd1, 3'd2, BURST_INCR);
        w_beats(0, 1, 1, 32'h55, 4'hC, -1);
        b_phase(resp, bid);
        chk("post_rst_resp", resp, RESP_OKAY);
        chk("post_rst_acc", {acc_n[7:0], acc_addr[0], acc_wdata[0],
                             acc_addr[1], acc_wdata[1]},
            {8'd2, 24'hA00, 32'h55, 24'hA04, 32'h56});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
